ps2_scan_fifo: RTL and testbench
================================

// Module: ps2_scan_fifo
// PURPOSE
//  Consumer stage directly downstream of the PS/2 keyboard front end. Takes each received
//  scan code (rx_scan_code + rx_released) over the ready/read handshake, acknowledges it with a
//  one-cycle rx_scan_read pulse and buffers it in a DEPTH-entry FIFO. A CPU/bus-side reader pops
//  entries. Provides level interrupt and sticky no-ack error status. Full FIFO back-pressures the front end.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of two, >=2
//  AW     4   log2(DEPTH); pointer width
// PORTS
//  clk                       in   1     system clock
//  rstn                      in   1     asynchronous reset, active-low
//  rx_scan_ready             in   1     front end holds a valid code (level until acknowledged)
//  rx_released               in   1     code is a key release (break)
//  rx_scan_code              in   8     scan code
//  rx_scan_read              out  1     one-cycle acknowledge to front end
//  tx_error_no_keyboard_ack  in   1     front-end transmit error flag
//  rd_en                     in   1     pop head entry (ignored when empty)
//  rd_data                   out  9     head entry {released, code}; valid when !empty
//  empty                     out  1     FIFO empty
//  full                      out  1     FIFO full
//  count                     out  AW+1  occupancy 0..DEPTH
//  clr                       in   1     synchronous flush of FIFO and error status
//  irq_en                    in   1     interrupt enable
//  irq                       out  1     registered: !empty & irq_en
//  err_sticky                out  1     set while tx_error_no_keyboard_ack=1, held until clr
// BEHAVIOUR
//  Reset (rstn=0, async): rx_scan_read=0, empty=1, full=0, count=0, irq=0, err_sticky=0,
//   rd_data=0, pointers=0, FSM=IDLE. Memory contents not reset.
//  FSM (capture side), states IDLE, ACK, WAIT_LOW:
//   IDLE: rx_scan_ready=1 & !full -> write {rx_released,rx_scan_code} at wr_ptr, go ACK.
//         rx_scan_ready=1 & full -> stay IDLE, no ack (front end keeps holding code).
//   ACK: rx_scan_read=1 for exactly this cycle; go WAIT_LOW.
//   WAIT_LOW: stay until rx_scan_ready=0, then IDLE. Guarantees one code -> one entry.
//  Latency: ready sampled high at edge N (IDLE, !full) -> entry visible, empty=0,
//   rx_scan_read=1 in cycle after edge N. Next capture no earlier than 3 cycles later.
//  rx_scan_read is a registered output driven only in ACK.
//  Pop: rd_en=1 & !empty -> rd_ptr advances at edge; rd_data is show-ahead (mem[rd_ptr]),
//   updates the cycle after the pop. rd_en while empty: no effect.
//  Simultaneous push+pop: count unchanged, both pointers advance. Push when full is
//   impossible (FSM gated on !full evaluated pre-pop); a pop the same cycle does not enable push.
//  Push into empty with rd_en=1 same cycle: pop ignored, count becomes 1.
//  Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
//  clr (priority over push/pop): pointers=0, count=0, err_sticky=0 next cycle; an entry
//   written same cycle is discarded. FSM not affected: in-flight ACK/WAIT_LOW completes.
//  err_sticky: set at any edge with tx_error_no_keyboard_ack=1 (unless clr same cycle; clr wins).
//  irq registered: irq(t+1) = !empty_next & irq_en; drops the cycle after last pop.
//  Reset mid-handshake: FSM to IDLE, rx_scan_read=0; a still-held code is re-captured after reset.
// TESTING
//  1 Reset: rstn low mid-ACK -> rx_scan_read=0, empty=1, count=0 immediately (async).
//  2 Single code: ready=1, code=0x1C, released=0 held until ack -> one rx_scan_read pulse,
//    rd_data=0x01C, count=1; ready held 5 extra cycles -> still count=1.
//  3 Fill: 17 codes 0x01..0x11, no reads -> count=16, full=1, 17th unacked; one pop ->
//    0x11 captured, rd order 0x01..0x11, count back to 16 then drains to 0, empty=1.
//  4 Push/pop same cycle at count=3 -> count stays 3; rd_en on empty -> no change.
//  5 Release code: released=1, code=0xF0 -> rd_data=0x1F0; irq_en=1 -> irq=1 until last pop.
//  6 tx_error pulse 1 cycle -> err_sticky=1 held; clr with 4 entries -> count=0, err_sticky=0.

Source files
------------

// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo
//   Takes scan codes from the PS/2 keyboard front end over a ready/read
//   handshake and buffers them for a CPU/bus-side reader.
//   Each accepted code is stored as {released, code} in a DEPTH-entry FIFO.
//   A full FIFO holds off the front end, which keeps presenting its code
//   until there is room. The block also provides a level interrupt and a
//   sticky flag for front-end "no keyboard ack" errors.
//
// Ports
//   clk_i, rstn_i               clock; asynchronous active-low reset
//   rx_scan_ready_i             front end holds a valid code (level)
//   rx_released_i               code is a key release (break)
//   rx_scan_code_i[7:0]         scan code
//   rx_scan_read_o              one-cycle acknowledge to the front end
//   tx_error_no_keyboard_ack_i  front-end transmit error flag
//   rd_en_i                     pop the head entry (ignored when empty)
//   rd_data_o[8:0]              head entry {released, code}; zero when empty
//   empty_o, full_o             FIFO status
//   count_o[AW:0]               occupancy, 0..DEPTH
//   clr_i                       synchronous flush of FIFO and error status
//   irq_en_i, irq_o             interrupt enable; registered !empty & irq_en
//   err_sticky_o                set by tx error, held until clr
//
// Capture FSM
//   state      | meaning
//   S_IDLE     | waiting for a code; captures it if the FIFO is not full
//   S_ACK      | rx_scan_read pulses high for this one cycle
//   S_WAIT_LOW | waits for the front end to drop ready (one code, one entry)

module ps2_scan_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          rx_scan_ready_i,
  input  logic          rx_released_i,
  input  logic [7:0]    rx_scan_code_i,
  output logic          rx_scan_read_o,
  input  logic          tx_error_no_keyboard_ack_i,
  input  logic          rd_en_i,
  output logic [8:0]    rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  input  logic          clr_i,
  input  logic          irq_en_i,
  output logic          irq_o,
  output logic          err_sticky_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            read_q;
  logic            irq_q, irq_d;
  logic            err_q, err_d;
  logic [8:0]      mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            empty;
  logic            full;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Capture side. The full check uses the pre-pop occupancy, so a pop in
  // the same cycle never lets a push through into a full FIFO.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_scan_ready_i && !full) begin
          push    = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:      state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!rx_scan_ready_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pointer / occupancy / status update. clr overrides push and pop, but
  // the capture FSM still finishes its handshake, so a code captured in
  // the clr cycle is acknowledged and then discarded.
  always_comb begin
    pop      = rd_en_i && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (tx_error_no_keyboard_ack_i) err_d = 1'b1;
    end
    irq_d = irq_en_i && (count_d != '0);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      read_q   <= 1'b0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      read_q   <= push;
      irq_q    <= irq_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; a stale word is never visible because rd_data
  // is forced to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {rx_released_i, rx_scan_code_i};
  end

  assign rd_data_o      = empty ? 9'h000 : mem_q[rd_ptr_q];
  assign rx_scan_read_o = read_q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign count_o        = count_q;
  assign irq_o          = irq_q;
  assign err_sticky_o   = err_q;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
module tb_ps2_scan_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_ready, rx_rel;
  logic [7:0]    rx_code;
  logic          rx_read;
  logic          txerr;
  logic          rd_en;
  logic [8:0]    rd_data;
  logic          empty, full;
  logic [AW:0]   count;
  logic          clr, irq_en, irq, err;

  int checks = 0;
  int errors = 0;

  ps2_scan_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i                      (clk),
    .rstn_i                     (rstn),
    .rx_scan_ready_i            (rx_ready),
    .rx_released_i              (rx_rel),
    .rx_scan_code_i             (rx_code),
    .rx_scan_read_o             (rx_read),
    .tx_error_no_keyboard_ack_i (txerr),
    .rd_en_i                    (rd_en),
    .rd_data_o                  (rd_data),
    .empty_o                    (empty),
    .full_o                     (full),
    .count_o                    (count),
    .clr_i                      (clr),
    .irq_en_i                   (irq_en),
    .irq_o                      (irq),
    .err_sticky_o               (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored entries plus a description of the
  // front-end contract: one capture per assertion of ready, a single ack
  // cycle, then ready must be seen low before another code is taken.
  logic [8:0] mq[$];
  bit         m_armed, m_ack_cycle, m_pu, m_po;
  logic       m_read, m_irq, m_err;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_armed = 1'b1; m_ack_cycle = 1'b0;
      m_read = 1'b0; m_irq = 1'b0; m_err = 1'b0;
    end else begin
      m_po = rd_en && (mq.size() > 0);
      m_pu = m_armed && rx_ready && (mq.size() < DEPTH);
      if (clr) begin
        mq.delete();
        m_err = 1'b0;
      end else begin
        if (m_po) void'(mq.pop_front());
        if (m_pu) mq.push_back({rx_rel, rx_code});
        if (txerr) m_err = 1'b1;
      end
      m_read = m_pu;
      if (m_pu) begin
        m_armed = 1'b0; m_ack_cycle = 1'b1;
      end else if (m_ack_cycle) begin
        m_ack_cycle = 1'b0;
      end else if (!m_armed && !rx_ready) begin
        m_armed = 1'b1;
      end
      m_irq = irq_en && (mq.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("rx_scan_read", rx_read, m_read);
      chk("irq", irq, m_irq);
      chk("err_sticky", err, m_err);
      if (mq.size() > 0) chk("rd_data", rd_data, mq[0]);
    end
  end

  task automatic wait_read();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_read && n < 50);
    chk("ack_seen", rx_read, 1);
  endtask

  // Front-end emulation: present a code, hold it until acked (plus extra
  // cycles), drop ready and leave the capture side back in its idle state.
  task automatic send(input logic [7:0] c, input logic r, input int extra);
    rx_code = c; rx_rel = r; rx_ready = 1'b1;
    wait_read();
    repeat (extra) @(posedge clk);
    @(posedge clk); #1 rx_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    rd_en = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; rx_ready = 1'b0; rx_rel = 1'b0; rx_code = 8'h00;
    txerr = 1'b0; rd_en = 1'b0; clr = 1'b0; irq_en = 1'b0;
    #1;
    chk("rst_read", rx_read, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_irq", irq, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // single code, ready held 5 extra cycles
    send(8'h1C, 1'b0, 5);
    @(negedge clk);
    chk("single_rd_data", rd_data, 9'h01C);
    chk("single_count", count, 1);
    @(posedge clk); #1;
    drain();

    // async reset in the middle of the ack, code re-captured afterwards
    rx_code = 8'h2A; rx_rel = 1'b0; rx_ready = 1'b1;
    wait_read();
    #1 rstn = 1'b0;
    #1;
    chk("midack_read", rx_read, 0);
    chk("midack_empty", empty, 1);
    chk("midack_count", count, 0);
    @(posedge clk); #1 rstn = 1'b1;
    wait_read();
    chk("recapture_data", rd_data, 9'h02A);
    @(posedge clk); #1 rx_ready = 1'b0;
    @(posedge clk); #1;
    drain();

    // fill to full, 17th code held off until one pop
    for (int i = 1; i <= DEPTH; i++) send(8'(i), 1'b0, 0);
    rx_code = 8'h11; rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_no_ack", rx_read, 0);
    chk("fill_head", rd_data, 9'h001);
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    wait_read();
    chk("refill_count", count, 16);
    @(posedge clk); #1 rx_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rd_en = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      chk("fifo_order", rd_data, k);
      @(negedge clk);
    end
    rd_en = 1'b0;
    chk("drained_empty", empty, 1);
    chk("drained_count", count, 0);
    @(posedge clk); #1;

    // simultaneous push and pop at count 3, then rd_en on empty
    send(8'h21, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    send(8'h23, 1'b0, 0);
    rx_code = 8'h24; rx_ready = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    @(negedge clk);
    chk("pushpop_count", count, 3);
    chk("pushpop_ack", rx_read, 1);
    chk("pushpop_head", rd_data, 9'h022);
    @(posedge clk); #1 rx_ready = 1'b0;
    @(posedge clk); #1;
    drain();
    rd_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rd_en = 1'b0;
    @(negedge clk);
    chk("empty_pop_count", count, 0);
    chk("empty_pop_empty", empty, 1);

    // release code and interrupt
    @(posedge clk); #1 irq_en = 1'b1;
    send(8'hF0, 1'b1, 0);
    @(negedge clk);
    chk("release_data", rd_data, 9'h1F0);
    chk("irq_set", irq, 1);
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    @(negedge clk);
    chk("irq_drop", irq, 0);

    // sticky error, then clr with 4 entries
    @(posedge clk); #1 txerr = 1'b1;
    @(posedge clk); #1 txerr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_held", err, 1);
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0, 0);
    @(negedge clk);
    chk("preclr_count", count, 4);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_count", count, 0);
    chk("clr_err", err, 0);
    chk("clr_irq", irq, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
